// File: rtl/lc3_pkg.sv
// lc3_pkg: types and constants shared across the LC-3 datapath.
//   word_t            16-bit machine word
//   aluk_e            ALU operation codes
//   a2m_e             ADDR2MUX select codes
//   pcmux_e           PCMUX select codes
//   marmux_e          MARMUX select codes
//   CC_N / CC_Z / CC_P  one-hot condition code values, packed as {N,Z,P}
//   sext()            sign-extend the low 'bits' bits of a word
//   cc_of()           condition code that a given bus value produces
package lc3_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        ALU_NOT   = 2'b00,
        ALU_AND   = 2'b01,
        ALU_ADD   = 2'b10,
        ALU_PASSA = 2'b11
    } aluk_e;

    typedef enum logic [1:0] {
        A2M_OFF11 = 2'b00,
        A2M_OFF9  = 2'b01,
        A2M_OFF6  = 2'b10,
        A2M_ZERO  = 2'b11
    } a2m_e;

    typedef enum logic [1:0] {
        PCMUX_ADDER = 2'b00,
        PCMUX_BUS   = 2'b01,
        PCMUX_INC   = 2'b10,
        PCMUX_HOLD  = 2'b11
    } pcmux_e;

    typedef enum logic {
        MARMUX_ZEXT8 = 1'b0,
        MARMUX_ADDER = 1'b1
    } marmux_e;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    // Shift the field to the top of the word, then arithmetic-shift it back
    // down so the field's MSB is replicated into the upper bits.
    function automatic word_t sext(input word_t v, input int unsigned bits);
        word_t up;
        up = v << (16 - bits);
        return word_t'($signed(up) >>> (16 - bits));
    endfunction

    function automatic logic [2:0] cc_of(input word_t v);
        if (v[15]) begin
            return CC_N;
        end else if (v == 16'h0000) begin
            return CC_Z;
        end else begin
            return CC_P;
        end
    endfunction

endpackage

// File: rtl/lc3_reg.sv
// lc3_reg: loadable register with asynchronous active-low reset.
//   clk       rising-edge clock
//   rst_n     async active-low reset, forces RESET_VAL
//   ld        load enable; in_data is captured on the rising edge
//   in_data   next value
//   out_data  current value
module lc3_reg #(
    parameter int unsigned          WIDTH     = 16,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= RESET_VAL;
        end else if (ld) begin
            out_data <= in_data;
        end
    end

endmodule

// File: rtl/lc3_datapath.sv
// lc3_datapath: LC-3 datapath driven by per-cycle control strobes.
// Holds the register file, ALU, address adder, PC/IR/MAR/MDR/CC registers,
// word-addressed memory and the internal bus. There are no data ports; the
// control unit observes ir.out_data, cc.out_data and pc.out_data directly.
//
// Ports (all inputs):
//   clk, rst_n                    clock, async active-low reset
//   ld_ir, ld_reg, ld_pc, ld_cc   register load strobes (bus / PCMUX / f(bus))
//   ld_mar, ld_mdr                MAR and MDR load strobes
//   dr, sr1, sr2                  register file destination / read selects
//   aluk                          ALU operation
//   a1m_sel, a2m_sel              address adder operand selects
//   pcmux_sel, marmux_sel         PCMUX / MARMUX selects
//   gate_alu, gate_pc,
//   gate_marmux, gate_mdr         bus drivers, prioritised in that order
//   mem_en, mem_rw                memory enable, 1 = write / 0 = read
module lc3_datapath
    import lc3_pkg::*;
#(
    parameter word_t       PC_RESET  = 16'h3000,
    parameter int unsigned MEM_WORDS = 65536,
    parameter string       MEM_INIT  = ""
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld_ir,
    input  logic       ld_reg,
    input  logic [2:0] dr,
    input  logic [2:0] sr1,
    input  logic [2:0] sr2,
    input  logic [1:0] aluk,
    input  logic       gate_alu,
    input  logic       a1m_sel,
    input  logic [1:0] a2m_sel,
    input  logic       ld_pc,
    input  logic [1:0] pcmux_sel,
    input  logic       gate_pc,
    input  logic       marmux_sel,
    input  logic       gate_marmux,
    input  logic       ld_cc,
    input  logic       ld_mar,
    input  logic       ld_mdr,
    input  logic       mem_en,
    input  logic       mem_rw,
    input  logic       gate_mdr
);

    word_t      bus;
    word_t      ir_q, pc_q, mar_q, mdr_q;
    logic [2:0] cc_q;

    word_t      rf [8];
    word_t      mem [MEM_WORDS];

    word_t      sr1_data, sr2_data;
    word_t      alu_b, alu_out;
    word_t      addr1, addr2, adder_out;
    word_t      marmux_out, pcmux_out;
    word_t      mdr_in, mem_rdata, mem_addr;
    logic       mdr_ld;
    logic [2:0] cc_in;

    aluk_e   aluk_op;
    a2m_e    a2m_op;
    pcmux_e  pcmux_op;
    marmux_e marmux_op;

    assign aluk_op   = aluk_e'(aluk);
    assign a2m_op    = a2m_e'(a2m_sel);
    assign pcmux_op  = pcmux_e'(pcmux_sel);
    assign marmux_op = marmux_e'(marmux_sel);

    // ------------------------------------------------------------------
    // Register file: two combinational read ports, one write port.
    // A read of the register being written returns the old value until
    // the edge, since the array only changes on the clock.
    // ------------------------------------------------------------------
    assign sr1_data = rf[sr1];
    assign sr2_data = rf[sr2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else if (ld_reg) begin
            rf[dr] <= bus;
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign alu_b = ir_q[5] ? sext(ir_q, 5) : sr2_data;

    always_comb begin
        alu_out = sr1_data;
        case (aluk_op)
            ALU_NOT:   alu_out = ~sr1_data;
            ALU_AND:   alu_out = sr1_data & alu_b;
            ALU_ADD:   alu_out = sr1_data + alu_b;
            ALU_PASSA: alu_out = sr1_data;
            default:   alu_out = sr1_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Address adder and the muxes around it
    // ------------------------------------------------------------------
    assign addr1 = a1m_sel ? pc_q : sr1_data;

    always_comb begin
        addr2 = '0;
        case (a2m_op)
            A2M_OFF11: addr2 = sext(ir_q, 11);
            A2M_OFF9:  addr2 = sext(ir_q, 9);
            A2M_OFF6:  addr2 = sext(ir_q, 6);
            A2M_ZERO:  addr2 = '0;
            default:   addr2 = '0;
        endcase
    end

    assign adder_out  = addr1 + addr2;
    assign marmux_out = (marmux_op == MARMUX_ADDER) ? adder_out : {8'h00, ir_q[7:0]};

    always_comb begin
        pcmux_out = pc_q;
        case (pcmux_op)
            PCMUX_ADDER: pcmux_out = adder_out;
            PCMUX_BUS:   pcmux_out = bus;
            PCMUX_INC:   pcmux_out = pc_q + 16'd1;
            PCMUX_HOLD:  pcmux_out = pc_q;
            default:     pcmux_out = pc_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus: a priority mux rather than tri-state, so conflicting gates
    // resolve deterministically and an idle bus reads as zero.
    // ------------------------------------------------------------------
    always_comb begin
        bus = '0;
        if (gate_alu) begin
            bus = alu_out;
        end else if (gate_pc) begin
            bus = pc_q;
        end else if (gate_marmux) begin
            bus = marmux_out;
        end else if (gate_mdr) begin
            bus = mdr_q;
        end
    end

    assign cc_in = cc_of(bus);

    // ------------------------------------------------------------------
    // Memory: combinational read from MAR, write of MDR on the edge.
    // The write is qualified by rst_n so a reset asserted mid-cycle
    // cancels a write that was set up for that edge.
    // ------------------------------------------------------------------
    assign mem_addr  = word_t'(32'(mar_q) % MEM_WORDS);
    assign mem_rdata = mem[mem_addr];

    always_ff @(posedge clk) begin
        if (rst_n && mem_en && mem_rw) begin
            mem[mem_addr] <= mdr_q;
        end
    end

    // MDR takes memory data on a read, the bus when memory is idle, and
    // holds during a write so the value being stored stays stable.
    assign mdr_in = mem_en ? mem_rdata : bus;
    assign mdr_ld = ld_mdr && !(mem_en && mem_rw);

    // ------------------------------------------------------------------
    // Architectural registers
    // ------------------------------------------------------------------
    lc3_reg #(.WIDTH(16), .RESET_VAL(16'h0000)) ir (
        .clk(clk), .rst_n(rst_n), .ld(ld_ir), .in_data(bus), .out_data(ir_q)
    );

    lc3_reg #(.WIDTH(16), .RESET_VAL(PC_RESET)) pc (
        .clk(clk), .rst_n(rst_n), .ld(ld_pc), .in_data(pcmux_out), .out_data(pc_q)
    );

    lc3_reg #(.WIDTH(3), .RESET_VAL(CC_Z)) cc (
        .clk(clk), .rst_n(rst_n), .ld(ld_cc), .in_data(cc_in), .out_data(cc_q)
    );

    lc3_reg #(.WIDTH(16), .RESET_VAL(16'h0000)) mar (
        .clk(clk), .rst_n(rst_n), .ld(ld_mar), .in_data(bus), .out_data(mar_q)
    );

    lc3_reg #(.WIDTH(16), .RESET_VAL(16'h0000)) mdr (
        .clk(clk), .rst_n(rst_n), .ld(mdr_ld), .in_data(mdr_in), .out_data(mdr_q)
    );

endmodule

// File: tb/tb_lc3_datapath.sv
// tb_lc3_datapath: scoreboard bench for lc3_datapath. Constants are built in
// the register file through the datapath itself (R6 = 1, then shift-and-add),
// expected results are queued as stimulus is driven and compared after the
// clock edge against the architectural state.
module tb_lc3_datapath;
    import lc3_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld_ir, ld_reg, gate_alu, a1m_sel, ld_pc, gate_pc;
    logic       marmux_sel, gate_marmux, ld_cc, ld_mar, ld_mdr;
    logic       mem_en, mem_rw, gate_mdr;
    logic [2:0] dr, sr1, sr2;
    logic [1:0] aluk, a2m_sel, pcmux_sel;

    always #5 clk = ~clk;

    lc3_datapath dut (
        .clk(clk), .rst_n(rst_n), .ld_ir(ld_ir), .ld_reg(ld_reg), .dr(dr),
        .sr1(sr1), .sr2(sr2), .aluk(aluk), .gate_alu(gate_alu),
        .a1m_sel(a1m_sel), .a2m_sel(a2m_sel), .ld_pc(ld_pc),
        .pcmux_sel(pcmux_sel), .gate_pc(gate_pc), .marmux_sel(marmux_sel),
        .gate_marmux(gate_marmux), .ld_cc(ld_cc), .ld_mar(ld_mar),
        .ld_mdr(ld_mdr), .mem_en(mem_en), .mem_rw(mem_rw), .gate_mdr(gate_mdr)
    );

    localparam int O_PC = 0, O_IR = 1, O_MAR = 2, O_MDR = 3, O_CC = 4, O_RF = 5, O_MEM = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] idx;
        logic [15:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    function automatic logic [15:0] observe(input int sel, input logic [15:0] idx);
        case (sel)
            O_PC:    return dut.pc.out_data;
            O_IR:    return dut.ir.out_data;
            O_MAR:   return dut.mar.out_data;
            O_MDR:   return dut.mdr.out_data;
            O_CC:    return {13'b0, dut.cc.out_data};
            O_RF:    return dut.rf[idx[2:0]];
            O_MEM:   return dut.mem[idx];
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [15:0] idx, input logic [15:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.idx = idx;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel, e.idx), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic clr();
        ld_ir = 0; ld_reg = 0; gate_alu = 0; a1m_sel = 0; ld_pc = 0; gate_pc = 0;
        marmux_sel = 0; gate_marmux = 0; ld_cc = 0; ld_mar = 0; ld_mdr = 0;
        mem_en = 0; mem_rw = 0; gate_mdr = 0;
        dr = 0; sr1 = 0; sr2 = 0; aluk = 0; a2m_sel = 0; pcmux_sel = 0;
    endtask

    task automatic alu(input logic [1:0] op, input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d);
        clr();
        aluk = op; sr1 = s1; sr2 = s2; dr = d;
        gate_alu = 1; ld_reg = 1;
        tick();
        clr();
    endtask

    // An ungated bus is zero, so this leaves IR[5] = 0 (register-mode ALU).
    task automatic clear_ir();
        clr();
        ld_ir = 1;
        tick();
        clr();
    endtask

    // R[d] <= val using only R6 = 1 and register-mode ADD/AND/NOT.
    task automatic build(input logic [2:0] d, input logic [15:0] val);
        clear_ir();
        alu(ALU_NOT, 3'd6, 3'd6, d);
        alu(ALU_AND, d, 3'd6, d);
        for (int b = 15; b >= 0; b--) begin
            alu(ALU_ADD, d, d, d);
            if (val[b]) alu(ALU_ADD, d, 3'd6, d);
        end
    endtask

    task automatic pass_r7(input logic to_ir, input logic to_mar, input logic to_mdr, input logic to_pc);
        clr();
        aluk = ALU_PASSA; sr1 = 3'd7; gate_alu = 1;
        ld_ir = to_ir; ld_mar = to_mar; ld_mdr = to_mdr;
        ld_pc = to_pc; pcmux_sel = PCMUX_BUS;
        tick();
        clr();
    endtask

    task automatic set_ir(input logic [15:0] v);  build(3'd7, v); pass_r7(1, 0, 0, 0); endtask
    task automatic set_mar(input logic [15:0] v); build(3'd7, v); pass_r7(0, 1, 0, 0); endtask
    task automatic set_mdr(input logic [15:0] v); build(3'd7, v); pass_r7(0, 0, 1, 0); endtask

    task automatic mem_write(input logic [15:0] a, input logic [15:0] v);
        set_mar(a);
        set_mdr(v);
        clr();
        mem_en = 1; mem_rw = 1;
        tick();
        clr();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        rst_n = 0;
        // Strobes while in reset must be ignored.
        ld_pc = 1; pcmux_sel = PCMUX_INC; ld_cc = 1; gate_pc = 1; ld_mar = 1;
        repeat (2) @(posedge clk);
        #1;
        push("rst_pc", O_PC, 0, 16'h3000);
        push("rst_cc", O_CC, 0, 16'h0002);
        push("rst_ir", O_IR, 0, 16'h0000);
        push("rst_mar", O_MAR, 0, 16'h0000);
        push("rst_mdr", O_MDR, 0, 16'h0000);
        push("rst_r0", O_RF, 0, 16'h0000);
        drain();
        clr();
        rst_n = 1;

        // R6 = 1: NOT 0 = FFFF, doubled = FFFE, NOT = 0001.
        alu(ALU_NOT, 3'd0, 3'd0, 3'd6);
        alu(ALU_ADD, 3'd6, 3'd6, 3'd6);
        push("setup_r6", O_RF, 6, 16'h0001);
        alu(ALU_NOT, 3'd6, 3'd6, 3'd6);

        build(3'd1, 16'd5);
        push("build_r1", O_RF, 1, 16'h0005);
        drain();

        // Fetch
        mem_write(16'h3000, 16'h1262);
        clr(); gate_pc = 1; ld_mar = 1;
        push("fetch_mar", O_MAR, 0, 16'h3000); tick();
        clr(); pcmux_sel = PCMUX_INC; ld_pc = 1;
        push("fetch_pc", O_PC, 0, 16'h3001); tick();
        clr(); mem_en = 1; ld_mdr = 1;
        push("fetch_mdr", O_MDR, 0, 16'h1262); tick();
        clr(); gate_mdr = 1; ld_ir = 1;
        push("fetch_ir", O_IR, 0, 16'h1262); tick();

        // ADD R1, R1, #2 (read-during-write: old R1 visible before the edge)
        clr(); aluk = ALU_ADD; gate_alu = 1; ld_reg = 1; ld_cc = 1; dr = 1; sr1 = 1;
        check("rdw_old_r1", observe(O_RF, 1), 16'h0005);
        push("add_r1", O_RF, 1, 16'h0007);
        push("add_cc", O_CC, 0, 16'h0001);
        tick();

        // AND R2, R1, #0
        set_ir(16'h5460);
        clr(); aluk = ALU_AND; gate_alu = 1; ld_reg = 1; ld_cc = 1; dr = 2; sr1 = 1;
        push("and_r2", O_RF, 2, 16'h0000);
        push("and_cc", O_CC, 0, 16'h0002);
        tick();

        // NOT R3, R2
        clr(); aluk = ALU_NOT; gate_alu = 1; ld_reg = 1; ld_cc = 1; dr = 3; sr1 = 2;
        push("not_r3", O_RF, 3, 16'hFFFF);
        push("not_cc", O_CC, 0, 16'h0004);
        tick();

        // ADD R5, R1, #-1 (imm5 sign extension)
        set_ir(16'h1A7F);
        clr(); aluk = ALU_ADD; gate_alu = 1; ld_reg = 1; ld_cc = 1; dr = 5; sr1 = 1;
        push("addneg_r5", O_RF, 5, 16'h0006);
        push("addneg_cc", O_CC, 0, 16'h0001);
        tick();

        // LDR R4, R3, #2
        build(3'd3, 16'h4000);
        mem_write(16'h4002, 16'h8000);
        set_ir(16'h68C2);
        clr(); sr1 = 3; a1m_sel = 0; a2m_sel = A2M_OFF6; marmux_sel = MARMUX_ADDER;
        gate_marmux = 1; ld_mar = 1;
        push("ldr_mar", O_MAR, 0, 16'h4002); tick();
        clr(); mem_en = 1; ld_mdr = 1;
        push("ldr_mdr", O_MDR, 0, 16'h8000); tick();
        clr(); gate_mdr = 1; ld_reg = 1; ld_cc = 1; dr = 4;
        push("ldr_r4", O_RF, 4, 16'h8000);
        push("ldr_cc", O_CC, 0, 16'h0004);
        tick();

        // STR: MDR <- R5 + 0 through MARMUX, then two write cycles with
        // ld_mdr held and a different bus value (MDR must hold).
        set_mar(16'h4005);
        build(3'd5, 16'h1234);
        clr(); sr1 = 5; a1m_sel = 0; a2m_sel = A2M_ZERO; marmux_sel = MARMUX_ADDER;
        gate_marmux = 1; ld_mdr = 1;
        push("str_mdr", O_MDR, 0, 16'h1234); tick();
        clr(); mem_en = 1; mem_rw = 1; ld_mdr = 1; gate_alu = 1; aluk = ALU_NOT; sr1 = 0;
        push("str_mdr_hold", O_MDR, 0, 16'h1234);
        push("str_mem1", O_MEM, 16'h4005, 16'h1234);
        tick();
        push("str_mem2", O_MEM, 16'h4005, 16'h1234);
        tick();

        // BR: PC = 3001, offset9 = -2
        build(3'd7, 16'h3001);
        push("br_pc_load", O_PC, 0, 16'h3001);
        pass_r7(0, 0, 0, 1);
        set_ir(16'h0FFE);
        clr(); a1m_sel = 1; a2m_sel = A2M_OFF9; pcmux_sel = PCMUX_ADDER; ld_pc = 1;
        push("br_pc", O_PC, 0, 16'h2FFF); tick();

        // offset11 through MARMUX, PC held via PCMUX = 3
        clr(); a1m_sel = 1; a2m_sel = A2M_OFF11; marmux_sel = MARMUX_ADDER;
        gate_marmux = 1; ld_mar = 1; ld_pc = 1; pcmux_sel = PCMUX_HOLD;
        push("off11_mar", O_MAR, 0, 16'h2FFD);
        push("hold_pc", O_PC, 0, 16'h2FFF);
        tick();

        // zext(IR[7:0])
        clr(); marmux_sel = MARMUX_ZEXT8; gate_marmux = 1; ld_mar = 1;
        push("zext8_mar", O_MAR, 0, 16'h00FE); tick();

        // gate_pc with ld_pc: bus carries old PC
        clr(); gate_pc = 1; ld_mar = 1; ld_pc = 1; pcmux_sel = PCMUX_INC;
        push("oldpc_mar", O_MAR, 0, 16'h2FFF);
        push("oldpc_pc", O_PC, 0, 16'h3000);
        tick();

        // Bus priority
        clr(); gate_alu = 1; aluk = ALU_PASSA; sr1 = 3; gate_pc = 1; gate_marmux = 1; gate_mdr = 1; ld_mar = 1;
        push("prio_alu", O_MAR, 0, 16'h4000); tick();
        clr(); gate_pc = 1; gate_marmux = 1; marmux_sel = MARMUX_ZEXT8; gate_mdr = 1; ld_mar = 1;
        push("prio_pc", O_MAR, 0, 16'h3000); tick();
        clr(); gate_marmux = 1; marmux_sel = MARMUX_ZEXT8; gate_mdr = 1; ld_mar = 1;
        push("prio_marmux", O_MAR, 0, 16'h00FE); tick();
        clr(); gate_mdr = 1; ld_mar = 1;
        push("prio_mdr", O_MAR, 0, 16'h1234); tick();
        clr(); ld_mar = 1; ld_cc = 1;
        push("idle_bus_mar", O_MAR, 0, 16'h0000);
        push("idle_bus_cc", O_CC, 0, 16'h0002);
        tick();

        // Move PC and CC off their reset values before the reset test.
        clr(); gate_pc = 1; ld_cc = 1; ld_pc = 1; pcmux_sel = PCMUX_INC;
        push("pre_rst_pc", O_PC, 0, 16'h3001);
        push("pre_rst_cc", O_CC, 0, 16'h0001);
        tick();

        // Reset asserted mid-cycle with a write pending to M[4005].
        set_mar(16'h4005);
        set_mdr(16'h5555);
        clr(); mem_en = 1; mem_rw = 1;
        @(negedge clk);
        rst_n = 0;
        #1;
        push("midrst_pc", O_PC, 0, 16'h3000);
        push("midrst_cc", O_CC, 0, 16'h0002);
        push("midrst_r1", O_RF, 1, 16'h0000);
        push("midrst_mar", O_MAR, 0, 16'h0000);
        drain();
        @(posedge clk);
        #1;
        push("midrst_mem", O_MEM, 16'h4005, 16'h1234);
        push("midrst_mdr", O_MDR, 0, 16'h0000);
        drain();
        clr();
        rst_n = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
